// File: rtl/bcd_add_pkg.sv
// Shared types and constants for the BCD adder controller and datapath.
package bcd_add_pkg;

    localparam int unsigned StateCodeWidth = 4;
    localparam int unsigned NumCmds        = 7;

    localparam int unsigned CmdInit      = 0;
    localparam int unsigned CmdLoadA     = 1;
    localparam int unsigned CmdLoadB     = 2;
    localparam int unsigned CmdDisplayA  = 3;
    localparam int unsigned CmdDisplayB  = 4;
    localparam int unsigned CmdDisplayLs = 5;
    localparam int unsigned CmdDisplayMs = 6;

    typedef enum logic [StateCodeWidth-1:0] {
        StInit    = 4'd0,
        StWaitA   = 4'd1,
        StLoadA   = 4'd2,
        StShowA   = 4'd3,
        StWaitB   = 4'd4,
        StLoadB   = 4'd5,
        StShowB   = 4'd6,
        StWaitSum = 4'd7,
        StShowLs  = 4'd8,
        StWaitMs  = 4'd9,
        StShowMs  = 4'd10,
        StError   = 4'd15
    } state_e;

    typedef enum logic [1:0] {
        PhPre = 2'd0,
        PhReq = 2'd1,
        PhRel = 2'd2
    } phase_e;

    // One-hot request owned by a command state; zero for every other state.
    function automatic logic [NumCmds-1:0] cmd_onehot(state_e st);
        logic [NumCmds-1:0] oh;
        oh = '0;
        case (st)
            StInit:   oh[CmdInit]      = 1'b1;
            StLoadA:  oh[CmdLoadA]     = 1'b1;
            StShowA:  oh[CmdDisplayA]  = 1'b1;
            StLoadB:  oh[CmdLoadB]     = 1'b1;
            StShowB:  oh[CmdDisplayB]  = 1'b1;
            StShowLs: oh[CmdDisplayLs] = 1'b1;
            StShowMs: oh[CmdDisplayMs] = 1'b1;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic is_cmd_state(state_e st);
        return |cmd_onehot(st);
    endfunction

endpackage

// File: rtl/bcd_enter_debounce.sv
// Enter push-button conditioning: 2-flop synchronizer, stable-sample debounce,
// one-cycle pulse on the debounced rising edge.
module bcd_enter_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enter,
    output logic pulse
);

    localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          sync_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                level_prev_q;
    logic                pulse_q;

    // Any sample equal to the current level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], enter};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_add_controller.sv
// Sequences the bcd_add_datapath command handshakes from a single enter button.
// Optional handshake watchdog enabled by defining BCD_ADD_ACK_TIMEOUT_EN.
module bcd_add_controller
    import bcd_add_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enter,
    input  logic                      init_ack,
    input  logic                      load_a_ack,
    input  logic                      load_b_ack,
    input  logic                      display_a_ack,
    input  logic                      display_b_ack,
    input  logic                      display_ls_ack,
    input  logic                      display_ms_ack,
    output logic                      init,
    output logic                      load_a,
    output logic                      load_b,
    output logic                      display_a,
    output logic                      display_b,
    output logic                      display_ls,
    output logic                      display_ms,
    output logic                      busy,
    output logic [StateCodeWidth-1:0] state_code,
    output logic                      error
);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES and TIMEOUT_CYCLES must both be at least 1");
    end

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [NumCmds-1:0]   req_q, req_d;
    logic [NumCmds-1:0]   ack_vec;
    logic                 ack_cur;
    logic                 is_wait;
    logic                 enter_pulse;

`ifdef BCD_ADD_ACK_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoWidth-1:0] TmoMax = TmoWidth'(TIMEOUT_CYCLES - 1);
    logic [TmoWidth-1:0]  tmo_q, tmo_d;
`endif

    bcd_enter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset_n(reset_n),
        .enter  (enter),
        .pulse  (enter_pulse)
    );

    assign ack_vec[CmdInit]      = init_ack;
    assign ack_vec[CmdLoadA]     = load_a_ack;
    assign ack_vec[CmdLoadB]     = load_b_ack;
    assign ack_vec[CmdDisplayA]  = display_a_ack;
    assign ack_vec[CmdDisplayB]  = display_b_ack;
    assign ack_vec[CmdDisplayLs] = display_ls_ack;
    assign ack_vec[CmdDisplayMs] = display_ms_ack;

    // Only the current command's ack is looked at.
    assign ack_cur = |(ack_vec & cmd_onehot(state_q));
    assign is_wait = state_q inside {StWaitA, StWaitB, StWaitSum, StWaitMs};

    function automatic state_e next_state(state_e st);
        case (st)
            StInit:    return StWaitA;
            StWaitA:   return StLoadA;
            StLoadA:   return StShowA;
            StShowA:   return StWaitB;
            StWaitB:   return StLoadB;
            StLoadB:   return StShowB;
            StShowB:   return StWaitSum;
            StWaitSum: return StShowLs;
            StShowLs:  return StWaitMs;
            StWaitMs:  return StShowMs;
            StShowMs:  return StWaitA;
            default:   return st;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        req_d   = '0;
`ifdef BCD_ADD_ACK_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (is_cmd_state(state_q)) begin
            case (phase_q)
                PhPre: if (!ack_cur) phase_d = PhReq;
                PhReq: if (ack_cur) phase_d = PhRel;
                PhRel: begin
                    if (!ack_cur) begin
                        state_d = next_state(state_q);
                        phase_d = PhPre;
                    end
                end
                default: phase_d = PhPre;
            endcase
`ifdef BCD_ADD_ACK_TIMEOUT_EN
            // Count stays zero through PRE, so it restarts on every REQ entry.
            if (phase_q != PhPre) begin
                if (tmo_q == TmoMax) begin
                    state_d = StError;
                    phase_d = PhPre;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`endif
        end else if (is_wait && enter_pulse) begin
            state_d = next_state(state_q);
            phase_d = PhPre;
        end
        if (phase_d == PhReq) begin
            req_d = cmd_onehot(state_d);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StInit;
            phase_q <= PhPre;
            req_q   <= '0;
`ifdef BCD_ADD_ACK_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            req_q   <= req_d;
`ifdef BCD_ADD_ACK_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign init       = req_q[CmdInit];
    assign load_a     = req_q[CmdLoadA];
    assign load_b     = req_q[CmdLoadB];
    assign display_a  = req_q[CmdDisplayA];
    assign display_b  = req_q[CmdDisplayB];
    assign display_ls = req_q[CmdDisplayLs];
    assign display_ms = req_q[CmdDisplayMs];

    assign busy       = is_cmd_state(state_q);
    assign state_code = state_q;

`ifdef BCD_ADD_ACK_TIMEOUT_EN
    assign error = (state_q == StError);
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_add_controller.sv
// Self-checking bench for bcd_add_controller with a scoreboard of request order.
module tb_bcd_add_controller;
    import bcd_add_pkg::*;

    localparam int DEB = 4;
    localparam int TO  = 8;

    logic       clock, reset_n, enter;
    logic       init_ack, load_a_ack, load_b_ack, display_a_ack, display_b_ack;
    logic       display_ls_ack, display_ms_ack;
    logic       init, load_a, load_b, display_a, display_b, display_ls, display_ms;
    logic       busy, error;
    logic [3:0] state_code;

    logic [6:0] req;
    logic [6:0] req_prev = '0;
    logic [6:0] ack_q = '0;
    logic [6:0] ack_force = '0;
    logic [6:0] ack_block = '0;
    logic [6:0] acks;
    int         age [7] = '{default: 0};
    int         ack_delay = 0;
    bit         mon_en = 0;

    int errors = 0;
    int checks = 0;
    int exp_q [$];
    int exp_v;

    bcd_add_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enter         (enter),
        .init_ack      (init_ack),
        .load_a_ack    (load_a_ack),
        .load_b_ack    (load_b_ack),
        .display_a_ack (display_a_ack),
        .display_b_ack (display_b_ack),
        .display_ls_ack(display_ls_ack),
        .display_ms_ack(display_ms_ack),
        .init          (init),
        .load_a        (load_a),
        .load_b        (load_b),
        .display_a     (display_a),
        .display_b     (display_b),
        .display_ls    (display_ls),
        .display_ms    (display_ms),
        .busy          (busy),
        .state_code    (state_code),
        .error         (error)
    );

    assign req = {display_ms, display_ls, display_b, display_a, load_b, load_a, init};
    assign acks = ack_q | ack_force;
    assign {display_ms_ack, display_ls_ack, display_b_ack, display_a_ack,
            load_b_ack, load_a_ack, init_ack} = acks;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Datapath model: ack rises ack_delay+1 cycles after request, drops 1 cycle after it.
    always @(posedge clock) begin
        for (int i = 0; i < 7; i++) begin
            ack_q[i] <= req[i] && (age[i] >= ack_delay) && !ack_block[i];
            age[i]   <= req[i] ? age[i] + 1 : 0;
        end
    end

    // Scoreboard: every request rise must match the next expected command.
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if ($countones(req) > 1) begin
                errors++;
                $display("FAIL onehot: requests=%b, required at most one high", req);
            end
            for (int i = 0; i < 7; i++) begin
                if (req[i] && !req_prev[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_order: request %0d rose, required none", i);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (i != exp_v) begin
                            errors++;
                            $display("FAIL req_order: request %0d rose, required %0d", i, exp_v);
                        end
                    end
                end
            end
            req_prev <= req;
        end
    end

    task automatic wait_state(input logic [3:0] code, input int budget);
        int n = 0;
        while (state_code !== code && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic press(input int hold);
        enter = 1'b1;
        repeat (hold) @(negedge clock);
        enter = 1'b0;
        repeat (DEB + 6) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enter   = 1'b0;
        repeat (3) @(negedge clock);
        mon_en = 1;
        checks++;
        if (req !== 7'b0) begin
            errors++; $display("FAIL reset_requests: got %b, required 0", req);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b, required 1", busy);
        end
        checks++;
        if (state_code !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d, required 0", state_code);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b, required 0", error);
        end
        exp_q.push_back(CmdInit);
        reset_n = 1'b1;
        wait_state(4'd1, 50);
        checks++;
        if (state_code !== 4'd1) begin
            errors++; $display("FAIL init_to_wait_a: got %0d, required 1", state_code);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL wait_a_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_sequence();
        exp_q.push_back(CmdLoadA);
        exp_q.push_back(CmdDisplayA);
        enter = 1'b1;
        repeat (DEB + 3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (state_code !== 4'd1) begin
            errors++; $display("FAIL enter_latency_early: got %0d, required 1", state_code);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (state_code !== 4'd2) begin
            errors++; $display("FAIL enter_latency: got %0d, required 2", state_code);
        end
        repeat (2) @(negedge clock);
        enter = 1'b0;
        wait_state(4'd4, 60);
        checks++;
        if (state_code !== 4'd4) begin
            errors++; $display("FAIL seq_wait_b: got %0d, required 4", state_code);
        end
        repeat (DEB + 6) @(negedge clock);

        exp_q.push_back(CmdLoadB);
        exp_q.push_back(CmdDisplayB);
        press(DEB + 2);
        wait_state(4'd7, 60);
        checks++;
        if (state_code !== 4'd7) begin
            errors++; $display("FAIL seq_wait_sum: got %0d, required 7", state_code);
        end

        exp_q.push_back(CmdDisplayLs);
        press(DEB + 2);
        wait_state(4'd9, 60);
        checks++;
        if (state_code !== 4'd9) begin
            errors++; $display("FAIL seq_wait_ms: got %0d, required 9", state_code);
        end

        exp_q.push_back(CmdDisplayMs);
        press(DEB + 2);
        wait_state(4'd1, 60);
        checks++;
        if (state_code !== 4'd1) begin
            errors++; $display("FAIL seq_wrap_wait_a: got %0d, required 1", state_code);
        end
    endtask

    task automatic test_bounce();
        for (int g = 0; g < 3; g++) begin
            enter = 1'b1;
            repeat (DEB - 1) @(negedge clock);
            enter = 1'b0;
            repeat (DEB - 1) @(negedge clock);
        end
        repeat (12) @(negedge clock);
        checks++;
        if (state_code !== 4'd1) begin
            errors++; $display("FAIL bounce_no_advance: got %0d, required 1", state_code);
        end
        exp_q.push_back(CmdLoadA);
        exp_q.push_back(CmdDisplayA);
        enter = 1'b1;
        repeat (DEB) @(negedge clock);
        enter = 1'b0;
        wait_state(4'd4, 60);
        checks++;
        if (state_code !== 4'd4) begin
            errors++; $display("FAIL stable_press_advance: got %0d, required 4", state_code);
        end
        repeat (30) @(negedge clock);
        checks++;
        if (state_code !== 4'd4) begin
            errors++; $display("FAIL single_advance: got %0d, required 4", state_code);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ack_delay = 3;
        exp_q.push_back(CmdLoadB);
        enter = 1'b1;
        repeat (DEB) @(negedge clock);
        enter = 1'b0;
        while (!(load_b === 1'b1 && load_b_ack === 1'b1) && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!(load_b === 1'b1 && load_b_ack === 1'b1)) begin
            errors++;
            $display("FAIL reset_mid_setup: load_b=%b load_b_ack=%b, required both 1",
                     load_b, load_b_ack);
        end
        reset_n = 1'b0;
        ack_force[CmdInit] = 1'b1;
        @(negedge clock);
        checks++;
        if (load_b !== 1'b0) begin
            errors++; $display("FAIL reset_mid_drop: load_b=%b, required 0", load_b);
        end
        checks++;
        if (state_code !== 4'd0) begin
            errors++; $display("FAIL reset_mid_state: got %0d, required 0", state_code);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (init !== 1'b0) begin
                errors++; $display("FAIL init_waits_ack: init=%b at cycle %0d, required 0", init, i);
            end
        end
        exp_q.push_back(CmdInit);
        ack_force = '0;
        ack_delay = 0;
        wait_state(4'd1, 50);
        checks++;
        if (state_code !== 4'd1) begin
            errors++; $display("FAIL reset_mid_recover: got %0d, required 1", state_code);
        end
    endtask

    task automatic test_stall_press();
        exp_q.push_back(CmdLoadA);
        exp_q.push_back(CmdDisplayA);
        press(DEB + 2);
        wait_state(4'd4, 60);
        repeat (DEB + 6) @(negedge clock);
        ack_delay = 10;
        exp_q.push_back(CmdLoadB);
        exp_q.push_back(CmdDisplayB);
        enter = 1'b1;
        repeat (DEB) @(negedge clock);
        enter = 1'b0;
        wait_state(4'd6, 80);
        checks++;
        if (state_code !== 4'd6) begin
            errors++; $display("FAIL stall_show_b: got %0d, required 6", state_code);
        end
        enter = 1'b1;
        repeat (DEB + 2) @(negedge clock);
        enter = 1'b0;
        wait_state(4'd7, 80);
        repeat (30) @(negedge clock);
        checks++;
        if (state_code !== 4'd7) begin
            errors++; $display("FAIL stall_press_dropped: got %0d, required 7", state_code);
        end
        ack_delay = 0;
    endtask

`ifdef BCD_ADD_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(CmdInit);
        wait_state(4'd1, 50);
        ack_block[CmdLoadA] = 1'b1;
        exp_q.push_back(CmdLoadA);
        enter = 1'b1;
        repeat (DEB) @(negedge clock);
        enter = 1'b0;
        while (load_a !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (load_a !== 1'b1) begin
            errors++; $display("FAIL timeout_setup: load_a=%b, required 1", load_a);
        end
        repeat (TO - 1) @(negedge clock);
        checks++;
        if (state_code !== 4'd2 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: state=%0d error=%b, required 2 and 0", state_code, error);
        end
        @(negedge clock);
        checks++;
        if (state_code !== 4'd15 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_error: state=%0d error=%b, required 15 and 1", state_code, error);
        end
        checks++;
        if (req !== 7'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_outputs: req=%b busy=%b, required 0 and 0", req, busy);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (state_code !== 4'd15) begin
            errors++; $display("FAIL timeout_sticky: got %0d, required 15", state_code);
        end
        reset_n = 1'b0;
        ack_block = '0;
        @(negedge clock);
        checks++;
        if (state_code !== 4'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset: state=%0d error=%b, required 0 and 0", state_code, error);
        end
        exp_q.push_back(CmdInit);
        reset_n = 1'b1;
        wait_state(4'd1, 50);
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_bounce();
        test_reset_mid();
        test_stall_press();
`ifdef BCD_ADD_ACK_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
        end
`ifndef BCD_ADD_ACK_TIMEOUT_EN
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL error_tied_low: got %b, required 0", error);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
